dsp_systolic_acc_drain: RTL and testbench
=========================================

// Module: dsp_systolic_acc_drain
// PURPOSE
// - Result-side drain for the 18x18 signed systolic dot-product chain. It tracks which issued vectors are in flight and
//   accumulates the chain's per-vector result into one sum per frame (a multi-vector dot product).
// - Finished sums are buffered in a FIFO and presented on a valid/ready stream.
// - The DSP chain cannot stall, so backpressure is credit-based: in_ready gates issue into the chain.
// PARAMETERS
// - DSP_LATENCY    6   cycles from accepted issue edge to the edge where dsp_result holds that vector's sum (>=1)
// - RESULT_A_WIDTH 44  width of dsp_result (signed)
// - ACC_WIDTH      48  frame accumulator / out_data width (signed, >= RESULT_A_WIDTH)
// - LEN_WIDTH      8   width of out_count
// - FIFO_DEPTH     8   result FIFO entries (power of 2, >=2)
// PORTS
// - clk        in   1               single clock, all logic rising-edge
// - reset      in   1               synchronous, active-high
// - in_valid   in   1               upstream issues a vector into the DSP chain this cycle
// - in_last    in   1               issued vector is the last of its frame; qualified by in_valid
// - in_ready   out  1               credit available; an issue counts only when in_valid & in_ready
// - dsp_result in   RESULT_A_WIDTH  systolic chain output (signed)
// - out_valid  out  1               FIFO head holds a frame result
// - out_ready  in   1               downstream accepts when out_valid & out_ready
// - out_data   out  ACC_WIDTH       signed frame sum
// - out_count  out  LEN_WIDTH       vectors in frame, saturating at 2^LEN_WIDTH-1
// - out_ovf    out  1               signed overflow occurred anywhere in the frame's accumulation
// BEHAVIOUR
// - Reset: in_ready=0, out_valid=0, out_data=0, out_count=0, out_ovf=0. FIFO, in-flight tracker, accumulator, count and
//   ovf state all cleared. Results in flight when reset asserts are discarded, even if they arrive after reset releases.
//   in_ready=1 from the first cycle after reset deasserts (FIFO empty).
// - Issue tracking: a DSP_LATENCY-deep shift register of {v,last}. It is loaded with {in_valid&in_ready, in_last} and
//   zeroed by reset. Its output tap qualifies dsp_result on that edge. Upstream drives no DSP inputs while in_ready=0.
// - Accumulate on a qualified tap:
//   - ext = sign-extend(dsp_result) to ACC_WIDTH.
//   - First vector of a frame: acc<=ext, cnt<=1, ovf<=0. Otherwise acc<=acc+ext (wraps), cnt<=sat(cnt+1),
//     ovf<=ovf | (acc and ext have equal signs and the sum sign differs).
//   - Tap last=1: push {acc_next, cnt_next, ovf_next} into the FIFO on the same edge. The next qualified tap is the first
//     of a new frame. A single-vector frame (last on its first vector) is legal.
// - Credit:
//   - pending = number of last=1 entries in the shift register (counter: +1 on an accepted in_last, -1 at a last tap).
//   - in_ready = (fifo_count + pending) < FIFO_DEPTH. It is a registered-state function and never depends on out_ready.
//   - Non-last issues also need a credit slot, so a stalled FIFO eventually blocks all issue.
//   - Guarantee: a push never meets a full FIFO. Push and pop on the same edge are legal at any occupancy.
// - Output: out_valid=(fifo_count!=0). Fields are registered from the FIFO head and held stable while
//   out_valid & !out_ready. Latency when FIFO empty: the last vector's tap edge E -> out_valid=1 in the cycle after E
//   (DSP_LATENCY+1 cycles after issue). Back-to-back frames may produce one result per cycle.
// - Gaps: idle cycles (in_valid=0) inside a frame are allowed. The accumulator holds and unqualified dsp_result is ignored.
// - cnt saturates at 2^LEN_WIDTH-1 and does not affect acc.
// TESTING
// - Reset then single frame: one vector, in_last=1, dsp_result=-5 at tap -> out_data=-5, out_count=1, out_ovf=0; out_valid
//   rises exactly DSP_LATENCY+1 cycles after issue.
// - 4-vector frame with gaps, results 100,-30,7,2^43-1 -> out_data=2^43+76, out_count=4. Compare against a bench model
//   built from the chain's a*b sums.
// - out_ready=0 while issuing 1-vector frames each cycle -> in_ready drops after exactly 8 accepted issues; no loss; then
//   out_ready=1 drains 8 results in order.
// - Overflow: ACC_WIDTH=RESULT_A_WIDTH=44, two results 2^43-1 and 1 -> out_data=-2^43, out_ovf=1. The next frame has
//   out_ovf=0.
// - Reset asserted with 3 vectors in flight and 2 FIFO entries -> no out_valid after reset; the first later frame sum
//   excludes all pre-reset results.
// - Random 1000-cycle soak: random frame lengths 1-300, random in_valid/out_ready -> every frame matches the model and
//   out_count saturates at 255 for long frames.

Source files
------------

// File: rtl/dsp_systolic_acc_drain.sv
// rtl/dsp_systolic_acc_drain.sv - systolic chain result drain: frame accumulation, result FIFO, issue credit
module dsp_systolic_acc_drain #(
    parameter int DSP_LATENCY    = 6,
    parameter int RESULT_A_WIDTH = 44,
    parameter int ACC_WIDTH      = 48,
    parameter int LEN_WIDTH      = 8,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic [RESULT_A_WIDTH-1:0] dsp_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic [LEN_WIDTH-1:0]      out_count,
    output logic                      out_ovf
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 2;
    localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;

    // In-flight tracker: one {valid,last} pair per pipeline stage of the DSP chain
    logic [DSP_LATENCY-1:0] sr_v;
    logic [DSP_LATENCY-1:0] sr_last;
    logic                   tap_v;
    logic                   tap_last;
    logic                   issue;
    logic                   ready_en;
    logic [CW-1:0]          pending;
    logic [CW-1:0]          fifo_count;

    // Frame accumulator state
    logic                        in_frame;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [LEN_WIDTH-1:0]        cnt;
    logic [LEN_WIDTH-1:0]        cnt_next;
    logic                        ovf;
    logic                        ovf_next;

    // Result FIFO storage
    logic                 push;
    logic                 pop;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [ACC_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0] mem_cnt  [FIFO_DEPTH];
    logic                 mem_ovf  [FIFO_DEPTH];

    // Credit covers both queued results and frames whose last vector is still in the chain,
    // so a push can never find the FIFO full.
    assign in_ready = ready_en && ((fifo_count + pending) < DEPTH_C);
    assign issue    = in_valid && in_ready;
    assign tap_v    = sr_v[DSP_LATENCY-1];
    assign tap_last = sr_last[DSP_LATENCY-1];
    assign push     = tap_v && tap_last;
    assign pop      = out_valid && out_ready;

    assign out_valid = (fifo_count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_count = mem_cnt[rd_ptr];
    assign out_ovf   = mem_ovf[rd_ptr];

    assign ext = ACC_WIDTH'($signed(dsp_result));

    // Next accumulator values for a qualified tap (first vector restarts the frame)
    always_comb begin
        sum      = acc + ext;
        acc_next = ext;
        cnt_next = LEN_WIDTH'(1);
        ovf_next = 1'b0;
        if (in_frame) begin
            acc_next = sum;
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + LEN_WIDTH'(1);
            ovf_next = ovf | ((acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                              (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]));
        end
    end

    // Shift the issue record along with the chain and keep the outstanding-frame credit count
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_v     <= '0;
            sr_last  <= '0;
            pending  <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            sr_v[0]    <= issue;
            sr_last[0] <= issue && in_last;
            for (int i = 1; i < DSP_LATENCY; i++) begin
                sr_v[i]    <= sr_v[i-1];
                sr_last[i] <= sr_last[i-1];
            end
            pending <= pending + CW'(issue && in_last) - CW'(push);
        end
    end

    // Accumulate qualified chain results; unqualified dsp_result is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            in_frame <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else if (tap_v) begin
            acc      <= acc_next;
            cnt      <= cnt_next;
            ovf      <= ovf_next;
            in_frame <= !tap_last;
        end
    end

    // Result FIFO: push the completed frame on its last tap, pop on downstream handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_cnt[i]  <= '0;
                mem_ovf[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= acc_next;
                mem_cnt[wr_ptr]  <= cnt_next;
                mem_ovf[wr_ptr]  <= ovf_next;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dsp_systolic_acc_drain.sv
// tb/tb_dsp_systolic_acc_drain.sv - randomized and directed bench for dsp_systolic_acc_drain
module tb_dsp_systolic_acc_drain;
    localparam int L = 6;
    localparam longint MAX48 = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint MIN48 = -MAX48 - 1;
    localparam longint MAX44 = 64'sh0000_07FF_FFFF_FFFF;
    localparam longint MIN44 = -MAX44 - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_last, out_ready;
    logic [43:0] dsp_result;
    logic        in_ready, out_valid, out_ovf;
    logic [47:0] out_data;
    logic [7:0]  out_count;
    logic        in_ready44, out_valid44, out_ovf44;
    logic [43:0] out_data44;
    logic [7:0]  out_count44;

    dsp_systolic_acc_drain dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .dsp_result(dsp_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
    );

    dsp_systolic_acc_drain #(.ACC_WIDTH(44)) dut44 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready44),
        .dsp_result(dsp_result), .out_valid(out_valid44), .out_ready(out_ready),
        .out_data(out_data44), .out_count(out_count44), .out_ovf(out_ovf44)
    );

    typedef struct {
        logic [47:0] d48;
        logic [43:0] d44;
        logic [7:0]  cnt;
        logic        o48;
        logic        o44;
    } res_t;

    res_t        exp_q[$];
    longint      f_sum;
    int          f_n;
    logic        f_o48, f_o44;
    logic [43:0] sched_val [64];
    logic        sched_v   [64];
    int          edge_n;
    logic        ready_ok;
    logic [43:0] issue_val;
    int          n_vec, n_err, sat_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] rnd_res();
        int          m;
        longint      s;
        logic [43:0] r;
        m = $urandom_range(0, 2);
        s = 0;
        if (m == 0) begin
            r = {12'($urandom), $urandom};
        end else if (m == 1) begin
            for (int k = 0; k < 3; k++)
                s += longint'($signed(18'($urandom))) * longint'($signed(18'($urandom)));
            r = s[43:0];
        end else begin
            r = 44'($signed(8'($urandom)));
        end
        return r;
    endfunction

    task automatic model_clear();
        f_sum = 0;
        f_n   = 0;
        f_o48 = 1'b0;
        f_o44 = 1'b0;
    endtask

    task automatic model_accept(input logic [43:0] v, input logic last);
        res_t r;
        f_sum += longint'($signed(v));
        f_n++;
        if (f_sum > MAX48 || f_sum < MIN48) f_o48 = 1'b1;
        if (f_sum > MAX44 || f_sum < MIN44) f_o44 = 1'b1;
        if (last) begin
            r.d48 = f_sum[47:0];
            r.d44 = f_sum[43:0];
            r.cnt = (f_n > 255) ? 8'd255 : 8'(f_n);
            r.o48 = f_o48;
            r.o44 = f_o44;
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    task automatic cycle();
        logic acc, popn;
        int   e;
        res_t r;
        if (!reset) begin
            chk("in_ready", in_ready, ready_ok && (exp_q.size() < 8));
            chk("in_ready44", in_ready44, ready_ok && (exp_q.size() < 8));
            chk("out_valid44", out_valid44, out_valid);
        end
        acc  = !reset && in_valid && in_ready;
        popn = !reset && out_valid && out_ready;
        if (popn) begin
            chk("pop_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("data48", out_data, r.d48);
                chk("count48", out_count, r.cnt);
                chk("ovf48", out_ovf, r.o48);
                chk("data44", out_data44, r.d44);
                chk("count44", out_count44, r.cnt);
                chk("ovf44", out_ovf44, r.o44);
                if (r.cnt == 8'd255) sat_seen++;
            end
        end
        @(posedge clk);
        edge_n++;
        sched_v[edge_n % 64] = 1'b0;
        if (reset) begin
            exp_q.delete();
            model_clear();
            ready_ok = 1'b0;
        end else begin
            ready_ok = 1'b1;
            if (acc) begin
                sched_val[edge_n % 64] = issue_val;
                sched_v[edge_n % 64]   = 1'b1;
                model_accept(issue_val, in_last);
            end
        end
        @(negedge clk);
        e = edge_n + 1 - L;
        if (e > 0 && sched_v[e % 64]) dsp_result = sched_val[e % 64];
        else dsp_result = {12'($urandom), $urandom};
    endtask

    task automatic issue(input logic [43:0] v, input logic last);
        issue_val = v;
        in_valid  = 1'b1;
        in_last   = last;
        cycle();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!out_valid && k < 60) begin
            cycle();
            k++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 400) begin
            cycle();
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int lat, acc_cnt, rem;
        logic acc;
        n_vec = 0; n_err = 0; sat_seen = 0; edge_n = 0;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        dsp_result = '0; issue_val = '0; ready_ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sched_v[i]   = 1'b0;
            sched_val[i] = '0;
        end
        model_clear();
        @(negedge clk);
        repeat (3) cycle();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        reset = 1'b0;
        cycle();
        chk("ready_after_rst", in_ready, 1);

        // single-vector frame, latency
        issue(-44'sd5, 1'b1);
        out_ready = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            cycle();
            lat++;
        end
        chk("latency", lat, L + 1);
        chk("single_data", out_data, 48'hFFFF_FFFF_FFFB);
        chk("single_count", out_count, 1);
        chk("single_ovf", out_ovf, 0);
        out_ready = 1'b1;
        cycle();

        // 4-vector frame with gaps
        out_ready = 1'b0;
        issue(44'd100, 1'b0);
        cycle();
        issue(-44'sd30, 1'b0);
        repeat (2) cycle();
        issue(44'd7, 1'b0);
        cycle();
        issue(44'h7FF_FFFF_FFFF, 1'b1);
        wait_out();
        chk("gap_data", out_data, 48'h0800_0000_004C);
        chk("gap_count", out_count, 4);
        chk("gap_ovf", out_ovf, 0);
        out_ready = 1'b1;
        cycle();

        // credit exhaustion with stalled output
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        acc_cnt   = 0;
        for (int i = 0; i < 16; i++) begin
            issue_val = rnd_res();
            if (in_ready) acc_cnt++;
            cycle();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("credit_accepts", acc_cnt, 8);
        repeat (L + 2) cycle();
        drain();

        // overflow on the 44-bit accumulator, then a clean frame
        out_ready = 1'b0;
        issue(44'h7FF_FFFF_FFFF, 1'b0);
        issue(44'd1, 1'b1);
        wait_out();
        chk("ovf_data44", out_data44, 44'h800_0000_0000);
        chk("ovf_flag44", out_ovf44, 1);
        chk("ovf_data48", out_data, 48'h0800_0000_0000);
        chk("ovf_flag48", out_ovf, 0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        issue(44'd3, 1'b1);
        wait_out();
        chk("post_ovf_flag44", out_ovf44, 0);
        chk("post_ovf_data44", out_data44, 44'd3);
        out_ready = 1'b1;
        cycle();

        // reset with results queued and in flight
        out_ready = 1'b0;
        issue(44'd9, 1'b1);
        issue(44'd10, 1'b1);
        repeat (L + 1) cycle();
        chk("pre_rst_valid", out_valid, 1);
        issue(44'd1, 1'b0);
        issue(44'd2, 1'b0);
        issue(44'd3, 1'b0);
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("no_valid_after_rst", out_valid, 0);
        end
        out_ready = 1'b1;
        issue(44'd11, 1'b1);
        wait_out();
        chk("post_rst_data", out_data, 48'd11);
        chk("post_rst_count", out_count, 1);
        cycle();

        // random soak; first frame is long enough to saturate the count
        rem = 280;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            in_last   = (rem == 1);
            issue_val = rnd_res();
            acc       = in_valid && in_ready;
            cycle();
            if (acc) begin
                rem--;
                if (rem == 0)
                    rem = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 8);
            end
        end
        in_last = 1'b0;
        drain();
        chk("saturated_frame_seen", sat_seen > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
